// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared sizing helpers for the AXI-Stream FIFO
package axis_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - simple dual-port RAM, synchronous write, asynchronous read
module axis_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             aclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock first-word-fall-through AXI-Stream FIFO
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_DATA_DEPTH = 32
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [AXI_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [$clog2(AXI_DATA_DEPTH):0]   data_count
);

  localparam int PW = ptr_width(AXI_DATA_DEPTH);
  localparam int AW = PW - 1;

  if (!is_pow2(AXI_DATA_DEPTH)) begin : g_bad_depth
    $error("axis_sync_fifo: AXI_DATA_DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign data_count    = wr_ptr - rd_ptr;

  assign s_axis_tready = !fifo_full && !areset;
  assign m_axis_tvalid = !fifo_empty;

  assign wr_en = s_axis_tvalid && s_axis_tready;
  assign rd_en = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  axis_fifo_mem #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (AXI_DATA_DEPTH),
    .AW    (AW)
  ) u_mem (
    .aclk  (aclk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb/tb_axis_sync_fifo.sv - self-checking bench for axis_sync_fifo against a queue model
module tb_axis_sync_fifo;

  localparam int W = 32;
  localparam int D = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          empty;
  logic          full;
  logic [5:0]    count;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] model_q [$];
  bit do_wr;
  bit do_rd;

  axis_sync_fifo #(
    .AXI_DATA_WIDTH (W),
    .AXI_DATA_DEPTH (D)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .fifo_empty    (empty),
    .fifo_full     (full),
    .data_count    (count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO is a bounded queue; transfers follow from its occupancy.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      model_q.delete();
    end else begin
      do_wr = s_tvalid && (model_q.size() < D);
      do_rd = m_tready && (model_q.size() > 0);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(s_tdata);
    end
  end

  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("empty", {63'd0, empty}, {63'd0, model_q.size() == 0});
      chk("full", {63'd0, full}, {63'd0, model_q.size() == D});
      chk("count", {58'd0, count}, 64'(model_q.size()));
      chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, model_q.size() != 0});
      chk("s_tready", {63'd0, s_tready}, {63'd0, !areset && (model_q.size() < D)});
      if (model_q.size() != 0) chk("m_tdata", {32'd0, m_tdata}, {32'd0, model_q[0]});
    end
  end

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    areset   = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    cmp_en   = 1'b1;

    cycle(3);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_count", {58'd0, count}, 64'd0);
    areset = 1'b0;
    cycle(1);

    // single word
    s_tdata  = 32'hDEADBEEF;
    s_tvalid = 1'b1;
    cycle(1);
    s_tvalid = 1'b0;
    chk("one_tvalid", {63'd0, m_tvalid}, 64'd1);
    chk("one_tdata", {32'd0, m_tdata}, 64'hDEADBEEF);
    chk("one_count", {58'd0, count}, 64'd1);
    m_tready = 1'b1;
    cycle(1);
    m_tready = 1'b0;
    chk("one_empty", {63'd0, empty}, 64'd1);

    // fill, then hold a 33rd word
    for (int i = 0; i < D; i++) begin
      s_tdata  = $urandom;
      s_tvalid = 1'b1;
      cycle(1);
    end
    s_tdata = 32'h33333333;
    chk("fill_full", {63'd0, full}, 64'd1);
    chk("fill_s_tready", {63'd0, s_tready}, 64'd0);
    cycle(2);
    chk("fill_count_held", {58'd0, count}, 64'd32);
    s_tvalid = 1'b0;

    // slow drain
    for (int i = 0; i < D; i++) begin
      cycle(3);
      m_tready = 1'b1;
      cycle(1);
      m_tready = 1'b0;
    end
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_m_tvalid", {63'd0, m_tvalid}, 64'd0);

    // half fill, then concurrent streaming across several pointer wraps
    for (int i = 0; i < 16; i++) begin
      s_tdata  = 32'h1000 + i;
      s_tvalid = 1'b1;
      cycle(1);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tdata = 32'h2000 + i;
      cycle(1);
    end
    chk("stream_count", {58'd0, count}, 64'd16);
    chk("stream_head", {32'd0, m_tdata}, 64'h2000 + 84);
    m_tready = 1'b0;

    // top up to full
    for (int i = 0; i < 16; i++) begin
      s_tdata = 32'h3000 + i;
      cycle(1);
    end
    chk("refill_full", {63'd0, full}, 64'd1);

    // full boundary: read and offered write in the same cycle
    s_tdata  = 32'h4444;
    m_tready = 1'b1;
    cycle(1);
    m_tready = 1'b0;
    chk("bound_count31", {58'd0, count}, 64'd31);
    chk("bound_s_tready", {63'd0, s_tready}, 64'd1);
    cycle(1);
    s_tvalid = 1'b0;
    chk("bound_count32", {58'd0, count}, 64'd32);
    chk("bound_full", {63'd0, full}, 64'd1);

    // asynchronous reset in mid-cycle while streaming
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    cycle(2);
    #2;
    areset = 1'b1;
    #1;
    chk("arst_empty", {63'd0, empty}, 64'd1);
    chk("arst_full", {63'd0, full}, 64'd0);
    chk("arst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("arst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("arst_count", {58'd0, count}, 64'd0);
    cycle(2);
    areset   = 1'b0;
    m_tready = 1'b0;
    s_tdata  = 32'hCAFEF00D;
    cycle(1);
    s_tvalid = 1'b0;
    chk("post_rst_tdata", {32'd0, m_tdata}, 64'hCAFEF00D);
    chk("post_rst_count", {58'd0, count}, 64'd1);
    cycle(2);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
- Single-clock AXI-Stream FIFO buffering a slave stream (s_axis) into a master stream (m_axis).
- Provides first-word-fall-through output and status flags fifo_empty / fifo_full.
- Sits between a bursty producer and a consumer that drains in blocks, for example a consumer that waits for fifo_full and then reads DEPTH words.
- Integration may group the stream signals into the codebase's axis_if interface; ports are listed flattened here.

Parameters:
- AXI_DATA_WIDTH, 32, width of tdata in bits (≥1).
- AXI_DATA_DEPTH, 32, number of storage entries; must be a power of two ≥2; elaboration error otherwise.

Ports:
- aclk  input  1  sole clock; all state changes on its rising edge.
- areset  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  AXI_DATA_WIDTH  write data.
- s_axis_tvalid  input  1  write data valid.
- s_axis_tready  output  1  FIFO can accept a word.
- m_axis_tdata  output  AXI_DATA_WIDTH  head-of-queue data.
- m_axis_tvalid  output  1  head-of-queue data valid.
- m_axis_tready  input  1  downstream accepts a word.
- fifo_empty  output  1  no words stored.
- fifo_full  output  1  AXI_DATA_DEPTH words stored.
- data_count  output  $clog2(AXI_DATA_DEPTH)+1  number of stored words, 0..AXI_DATA_DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (areset=1, asynchronous assert, deassert sampled on aclk):
  - Write and read pointers cleared; data_count=0.
  - fifo_empty=1, fifo_full=0, m_axis_tvalid=0, s_axis_tready=0.
  - The storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- After reset, s_axis_tready = !fifo_full (forced 0 while areset=1); m_axis_tvalid = !fifo_empty.
- Write transfer: s_axis_tvalid & s_axis_tready at a rising edge.
  - Stores s_axis_tdata at wr_ptr; wr_ptr increments.
- Read transfer: m_axis_tvalid & m_axis_tready at a rising edge.
  - rd_ptr increments.
- m_axis_tdata: combinational read of mem[rd_ptr] (FWFT). It is stable while m_axis_tvalid=1 and no read transfer occurs. Its value is don't-care when empty.
- Latency: a word written at edge N into an empty FIFO gives m_axis_tvalid=1 and valid m_axis_tdata immediately after edge N (1-cycle latency). No bypass from s_axis to m_axis in the same cycle.
- Pointers: $clog2(DEPTH)+1 bits.
  - The low bits address memory and wrap naturally from DEPTH-1 to 0.
  - The MSB toggles on each wrap.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
- data_count = wr_ptr - rd_ptr, modulo 2^(ptr width); the flags are registered-pointer derived with no extra cycle.
- Simultaneous write and read with neither full nor empty: both occur; count unchanged.
- When full: tready=0, so no write occurs; a read in the same cycle frees one entry, and tready rises the next cycle.
- When empty: tvalid=0, so no read occurs; a write in the same cycle makes the FIFO non-empty the next cycle.
- tvalid/tready rules:
  - Master side never retracts m_axis_tvalid or changes m_axis_tdata until transferred (except on reset).
  - s_axis_tready does not depend combinationally on s_axis_tvalid.
- Order preserved strictly; no data loss or duplication.

Decomposition:
- Shared package axis_pkg: ptr_width function/localparam ($clog2(depth)+1) and a power-of-two check function.
- One natural sub-module: axis_fifo_mem, a simple dual-port RAM with synchronous write and asynchronous read (DEPTH x WIDTH).
- Pointer and flag logic live in the top.

Test Plan:
- Reset: hold areset=1 for 3 cycles -> fifo_empty=1, fifo_full=0, m_axis_tvalid=0, s_axis_tready=0, data_count=0. Assert areset asynchronously mid-stream -> flags return to reset values without waiting for a clock edge.
- Single word: write 0xDEADBEEF with m_axis_tready=0 -> next cycle m_axis_tvalid=1, m_axis_tdata=0xDEADBEEF, data_count=1. Then assert tready for one cycle -> fifo_empty=1.
- Fill: write 32 random words with tready=0 -> after the 32nd, fifo_full=1 and s_axis_tready=0. A 33rd word held with tvalid=1 is not accepted; data_count stays 32.
- Drain: from full, pulse m_axis_tready once every 4 cycles for 32 reads -> words come out in write order, fifo_empty=1 after the last, m_axis_tvalid=0.
- Wrap and concurrency: with the FIFO half full (16 words), stream writes and reads every cycle for 100 cycles -> data_count stays 16, pointers wrap at least twice, output sequence matches a scoreboard.
- Full boundary: at full, assert s_axis_tvalid and m_axis_tready in the same cycle -> one word read, no write that cycle, s_axis_tready=1 next cycle, data_count=31 and then back to 32.
